// File: rtl/exe_pkg.sv
// exe_pkg: shared definitions for the execute stage.
//   XLEN        : datapath width
//   ALU_*       : 4-bit ALU operation codes driven on ALUControlE
//   mul_state_t : iterative multiplier state encoding
package exe_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MULT = 4'b1000;
  localparam logic [3:0] ALU_MFHI = 4'b1001;
  localparam logic [3:0] ALU_MFLO = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/exe_mem_stage_mult_seq.sv
// mult_seq: iterative unsigned shift-add multiplier, one partial product per
// cycle, result latched into HI/LO. Only built when EXE_MULT_EN is defined.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a multiply (sampled in IDLE); a, b are captured then
//   a, b       : operands
//   busy       : FSM in BUSY
//   done       : FSM in DONE (HI/LO already hold the new product)
//   hi, lo     : upper / lower half of the last completed product
//
// state    | meaning
// ---------+--------------------------------------------------------
// MUL_IDLE | waiting for start
// MUL_BUSY | one shift-add step per cycle, counter runs CYCLES-1 .. 0
// MUL_DONE | HI/LO valid; one cycle, then back to IDLE
`ifdef EXE_MULT_EN
module mult_seq
  import exe_pkg::*;
#(
  parameter int W      = 32,
  parameter int CYCLES = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int CW = $clog2(CYCLES);

  mul_state_t       state, state_nx;
  logic [CW-1:0]    cnt;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [2*W-1:0]   acc_step;
  logic [W-1:0]     mplier;

  assign busy     = (state == MUL_BUSY);
  assign done     = (state == MUL_DONE);
  assign acc_step = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_nx = state;
    case (state)
      MUL_IDLE: if (start) state_nx = MUL_BUSY;
      MUL_BUSY: if (cnt == '0) state_nx = MUL_DONE;
      MUL_DONE: state_nx = MUL_IDLE;
      default:  state_nx = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        MUL_IDLE: begin
          if (start) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            cnt    <= CW'(CYCLES - 1);
          end
        end
        MUL_BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // The final step's sum goes straight into HI/LO so they are
          // already valid while the FSM sits in DONE.
          if (cnt == '0) {hi, lo} <= acc_step;
          else           cnt      <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`endif

// File: rtl/exe_mem_stage.sv
// exe_mem_stage: execute stage with MEM/WB operand forwarding, single-cycle
// ALU, optional iterative multiplier (HI/LO), and the EX/MEM pipeline register.
// Optional feature macro: EXE_MULT_EN (multiplier, HI/LO, MULT/MFHI/MFLO).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   regWriteE..RegDstE, ALUControlE: ID/EX control
//   RsE, RtE, RdE                  : register indices
//   data11, data22                 : register-file operands A, B
//   signExtendedValue1             : immediate, [10:6] is shamt
//   regWriteW, WriteRegW, ResultW  : writeback stage (forwarding source)
//   stallE                         : hold IF/ID/ID-EX while a multiply runs
//   regWriteM..WriteRegM           : EX/MEM register outputs
module exe_mem_stage #(
  parameter int XLEN       = exe_pkg::XLEN,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regWriteE,
  input  logic            MemToRegE,
  input  logic            MemWriteE,
  input  logic            ALUSrcE,
  input  logic            RegDstE,
  input  logic [3:0]      ALUControlE,
  input  logic [4:0]      RsE,
  input  logic [4:0]      RtE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] data11,
  input  logic [XLEN-1:0] data22,
  input  logic [XLEN-1:0] signExtendedValue1,
  input  logic            regWriteW,
  input  logic [4:0]      WriteRegW,
  input  logic [XLEN-1:0] ResultW,
  output logic            stallE,
  output logic            regWriteM,
  output logic            MemToRegM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUOutM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      WriteRegM
);

  import exe_pkg::*;

  if (MUL_CYCLES != XLEN) begin : g_bad_cfg
    $error("exe_mem_stage: MUL_CYCLES must equal XLEN");
  end

  logic [4:0]      write_reg_e;
  logic [4:0]      shamt;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_y;
  logic            is_mult;

  assign write_reg_e = RegDstE ? RdE : RtE;
  assign shamt       = signExtendedValue1[10:6];

  // MEM result is younger than WB, so it wins; $0 never forwards.
  always_comb begin
    src_a = data11;
    if (regWriteM && WriteRegM == RsE && RsE != 5'd0)
      src_a = ALUOutM;
    else if (regWriteW && WriteRegW == RsE && RsE != 5'd0)
      src_a = ResultW;
  end

  always_comb begin
    fwd_b = data22;
    if (regWriteM && WriteRegM == RtE && RtE != 5'd0)
      fwd_b = ALUOutM;
    else if (regWriteW && WriteRegW == RtE && RtE != 5'd0)
      fwd_b = ResultW;
  end

  assign src_b = ALUSrcE ? signExtendedValue1 : fwd_b;

`ifdef EXE_MULT_EN
  logic            mul_busy;
  logic            mul_done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  assign is_mult = (ALUControlE == ALU_MULT);

  // The multiply multiplies forwarded B, not SrcB: MULT is R-type.
  mult_seq #(
    .W      (XLEN),
    .CYCLES (MUL_CYCLES)
  ) u_mult (
    .clk   (clk),
    .rst   (rst),
    .start (is_mult && !mul_busy && !mul_done),
    .a     (src_a),
    .b     (fwd_b),
    .busy  (mul_busy),
    .done  (mul_done),
    .hi    (hi),
    .lo    (lo)
  );

  // DONE is the one cycle the MULT is allowed to retire.
  assign stallE = is_mult && !mul_done;
`else
  assign is_mult = 1'b0;
  assign stallE  = 1'b0;
`endif

  always_comb begin
    alu_y = '0;
    case (ALUControlE)
      ALU_AND:  alu_y = src_a & src_b;
      ALU_OR:   alu_y = src_a | src_b;
      ALU_XOR:  alu_y = src_a ^ src_b;
      ALU_NOR:  alu_y = ~(src_a | src_b);
      ALU_ADD:  alu_y = src_a + src_b;
      ALU_SUB:  alu_y = src_a - src_b;
      ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL:  alu_y = src_b << shamt;
      ALU_SRL:  alu_y = src_b >> shamt;
`ifdef EXE_MULT_EN
      ALU_MULT: alu_y = '0;
      ALU_MFHI: alu_y = hi;
      ALU_MFLO: alu_y = lo;
`else
      ALU_MULT, ALU_MFHI, ALU_MFLO: alu_y = '0;
`endif
      default:  alu_y = '0;
    endcase
  end

  // A stalled cycle pushes a bubble so MEM/WB never see a half-done MULT.
  always_ff @(posedge clk) begin
    if (rst || stallE) begin
      regWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else begin
      regWriteM  <= regWriteE && !is_mult;
      MemToRegM  <= MemToRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= alu_y;
      WriteDataM <= fwd_b;
      WriteRegM  <= write_reg_e;
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
module tb_exe_mem_stage;

`ifdef EXE_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_ADD = 4'd2, OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SUB = 4'd6, OP_SLT = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8, OP_MFHI = 4'd9, OP_MFLO = 4'd10, OP_NOR = 4'd12;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteE, MemToRegE, MemWriteE, ALUSrcE, RegDstE;
  logic [3:0]  ALUControlE;
  logic [4:0]  RsE, RtE, RdE;
  logic [31:0] data11, data22, signExtendedValue1;
  logic        regWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic        stallE, regWriteM, MemToRegM, MemWriteM;
  logic [31:0] ALUOutM, WriteDataM;
  logic [4:0]  WriteRegM;

  always #5 clk = ~clk;

  exe_mem_stage dut (
    .clk(clk), .rst(rst),
    .regWriteE(regWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
    .ALUSrcE(ALUSrcE), .RegDstE(RegDstE), .ALUControlE(ALUControlE),
    .RsE(RsE), .RtE(RtE), .RdE(RdE),
    .data11(data11), .data22(data22), .signExtendedValue1(signExtendedValue1),
    .regWriteW(regWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
    .stallE(stallE), .regWriteM(regWriteM), .MemToRegM(MemToRegM),
    .MemWriteM(MemWriteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WriteRegM(WriteRegM)
  );

  int total = 0;
  int bad   = 0;

  // reference model: expected EX/MEM contents, HI/LO and multiply age
  logic        m_rw = 1'b0, m_mtr = 1'b0, m_mw = 1'b0;
  logic [31:0] m_alu = '0, m_wd = '0, m_hi = '0, m_lo = '0;
  logic [4:0]  m_wr = '0;
  logic [63:0] m_prod = '0;
  int          m_age = 0;      // cycles the current MULT has spent in E
  logic        e_stall = 1'b0;
  logic        obs_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx != 5'd0 && m_rw && m_wr == idx) return m_alu;
    if (idx != 5'd0 && regWriteW && WriteRegW == idx) return ResultW;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return b << sh;
      OP_SRL:  return b >> sh;
      OP_MFHI: return MULT_EN ? m_hi : 32'd0;
      OP_MFLO: return MULT_EN ? m_lo : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check stallE mid-cycle, then the EX/MEM register after the edge.
  task automatic cyc();
    logic [31:0] a, b, sb, y, imm;
    logic        mult;
    logic        n_rw, n_mtr, n_mw;
    logic [31:0] n_alu, n_wd;
    logic [4:0]  n_wr;
    @(negedge clk);
    imm  = signExtendedValue1;
    a    = fwd(RsE, data11);
    b    = fwd(RtE, data22);
    sb   = ALUSrcE ? imm : b;
    mult = MULT_EN && (ALUControlE == OP_MULT);
    e_stall   = mult && (m_age < 33);
    obs_stall = stallE;
    chk("stallE", {31'b0, stallE}, {31'b0, e_stall});
    y = alu_ref(ALUControlE, a, sb, imm[10:6]);
    if (e_stall) begin
      n_rw = 0; n_mtr = 0; n_mw = 0; n_alu = 0; n_wd = 0; n_wr = 0;
    end else begin
      n_rw  = regWriteE && !mult;
      n_mtr = MemToRegE;
      n_mw  = MemWriteE;
      n_alu = y;
      n_wd  = b;
      n_wr  = RegDstE ? RdE : RtE;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_rw = 0; m_mtr = 0; m_mw = 0; m_alu = 0; m_wd = 0; m_wr = 0;
      m_hi = 0; m_lo = 0; m_age = 0;
    end else begin
      if (mult) begin
        if (m_age == 0)  m_prod = {32'b0, a} * {32'b0, b};
        if (m_age == 32) {m_hi, m_lo} = m_prod;
        m_age = (m_age == 33) ? 0 : m_age + 1;
      end
      m_rw = n_rw; m_mtr = n_mtr; m_mw = n_mw; m_alu = n_alu; m_wd = n_wd; m_wr = n_wr;
    end
    chk("regWriteM",  {31'b0, regWriteM}, {31'b0, m_rw});
    chk("MemToRegM",  {31'b0, MemToRegM}, {31'b0, m_mtr});
    chk("MemWriteM",  {31'b0, MemWriteM}, {31'b0, m_mw});
    chk("ALUOutM",    ALUOutM, m_alu);
    chk("WriteDataM", WriteDataM, m_wd);
    chk("WriteRegM",  {27'b0, WriteRegM}, {27'b0, m_wr});
  endtask

  task automatic set_e(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic alusrc, input logic regdst,
                       input logic rw);
    ALUControlE = op; RsE = rs; RtE = rt; RdE = rd; data11 = a; data22 = b;
    signExtendedValue1 = imm; ALUSrcE = alusrc; RegDstE = regdst; regWriteE = rw;
    MemToRegE = 1'b0; MemWriteE = 1'b0;
  endtask

  logic [3:0] ops [15] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                           4'd8, 4'd9, 4'd10, 4'd12, 4'd11, 4'd13, 4'd15};

  initial begin
    int n;
    logic [3:0] op;
    rst = 1'b1;
    regWriteW = 1'b0; WriteRegW = '0; ResultW = '0;
    set_e(OP_AND, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("reset_ALUOutM", ALUOutM, 32'd0);
    rst = 1'b0;

    // ADD without forwarding
    set_e(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 0, 1, 1);
    cyc();
    chk("add_out", ALUOutM, 32'd12);
    chk("add_wr", {27'b0, WriteRegM}, 32'd3);
    chk("add_rw", {31'b0, regWriteM}, 32'd1);

    // MEM beats WB; $0 never forwards; WB used once MEM no longer writes
    set_e(OP_ADD, 5'd0, 5'd0, 5'd4, 32'h10, 32'd0, 32'd0, 0, 1, 1);
    cyc();
    regWriteW = 1'b1; WriteRegW = 5'd4; ResultW = 32'h20;
    set_e(OP_ADD, 5'd4, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 0, 1, 0);
    cyc();
    chk("fwd_mem_prio", ALUOutM, 32'h10);
    set_e(OP_ADD, 5'd0, 5'd0, 5'd5, 32'h55, 32'd0, 32'd0, 0, 1, 0);
    cyc();
    chk("fwd_zero_reg", ALUOutM, 32'h55);
    set_e(OP_OR, 5'd4, 5'd0, 5'd5, 32'd0, 32'd0, 32'd0, 0, 1, 0);
    cyc();
    chk("fwd_wb", ALUOutM, 32'h20);
    regWriteW = 1'b0;

    // SLT signed, SRL/SLL by shamt, SUB with immediate
    set_e(OP_SLT, 5'd1, 5'd2, 5'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1, 0);
    cyc();
    chk("slt", ALUOutM, 32'd1);
    set_e(OP_SRL, 5'd1, 5'd2, 5'd6, 32'd0, 32'h8000_0000, 32'd4 << 6, 0, 1, 0);
    cyc();
    chk("srl", ALUOutM, 32'h0800_0000);
    set_e(OP_SLL, 5'd1, 5'd2, 5'd6, 32'd0, 32'h0000_0003, 32'd31 << 6, 0, 1, 0);
    cyc();
    chk("sll", ALUOutM, 32'h8000_0000);
    set_e(OP_SUB, 5'd1, 5'd2, 5'd6, 32'd3, 32'd0, 32'd5, 1, 0, 1);
    cyc();
    chk("sub_imm", ALUOutM, 32'hFFFF_FFFE);

    // MULT: stall length, bubbles, HI/LO readback
    set_e(OP_MULT, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (obs_stall) n++;
      else break;
    end
    chk("mult_stall_cycles", n, MULT_EN ? 32'd33 : 32'd0);
    chk("mult_aluout", ALUOutM, 32'd0);
    set_e(OP_MFHI, 5'd0, 5'd0, 5'd7, 0, 0, 0, 0, 1, 1);
    cyc();
    chk("mfhi", ALUOutM, MULT_EN ? 32'd1 : 32'd0);
    set_e(OP_MFLO, 5'd0, 5'd0, 5'd7, 0, 0, 0, 0, 1, 1);
    cyc();
    chk("mflo", ALUOutM, MULT_EN ? 32'hFFFF_FFFE : 32'd0);

    // reset in the 10th BUSY cycle aborts the multiply
    set_e(OP_MULT, 5'd1, 5'd2, 5'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cyc();
    rst = 1'b1;
    cyc();
    chk("rst_mid_out", ALUOutM, 32'd0);
    chk("rst_mid_rw", {31'b0, regWriteM}, 32'd0);
    rst = 1'b0;
    set_e(OP_MFHI, 5'd0, 5'd0, 5'd7, 0, 0, 0, 0, 1, 1);
    cyc();
    chk("rst_mid_mfhi", ALUOutM, 32'd0);

    // randomized traffic against the model; E held while the model stalls
    for (int i = 0; i < 600; i++) begin
      if (!e_stall) begin
        op = ops[$urandom_range(0, 14)];
        if (op == OP_MULT && $urandom_range(0, 2) != 0) op = OP_XOR;
        set_e(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), $urandom, $urandom,
              ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 2047)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        MemToRegE = 1'($urandom_range(0, 1));
        MemWriteE = 1'($urandom_range(0, 1));
      end
      regWriteW = 1'($urandom_range(0, 1));
      WriteRegW = 5'($urandom_range(0, 7));
      ResultW   = $urandom;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
